// File: rtl/adder_checker_pkg.sv
// Shared types and helpers for the adder response checker.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // "No failure recorded" marker; callers truncate it to their index width.
  localparam logic [31:0] IDX_NONE = '1;

  // Width that holds a+b without losing the carry-out.
  function automatic int sum_width(input int a_w, input int b_w);
    return ((a_w > b_w) ? a_w : b_w) + 1;
  endfunction

endpackage

// File: rtl/adder_checker_if.sv
// Stimulus/response bundle between the adder bench and the checker.
interface adder_checker_if
  import adder_chk_pkg::*;
#(
  parameter int A       = 8,
  parameter int B       = 8,
  parameter int ADDER_0 = sum_width(A, B),
  parameter int CNT_W   = 16
);

  logic               i_start;
  logic               i_valid;
  logic [A-1:0]       op_a;
  logic [B-1:0]       op_b;
  logic [ADDER_0-1:0] i_sum;

  logic               o_busy;
  logic               o_done;
  logic               o_mismatch;
  logic               o_error;
  logic [CNT_W-1:0]   o_pass_cnt;
  logic [CNT_W-1:0]   o_fail_cnt;
  logic [CNT_W-1:0]   o_first_fail_idx;

  // Bench side: drives operands, DUT sum and start; observes the verdict.
  modport master (
    output i_start, i_valid, op_a, op_b, i_sum,
    input  o_busy, o_done, o_mismatch, o_error,
    input  o_pass_cnt, o_fail_cnt, o_first_fail_idx
  );

  // Checker side.
  modport slave (
    input  i_start, i_valid, op_a, op_b, i_sum,
    output o_busy, o_done, o_mismatch, o_error,
    output o_pass_cnt, o_fail_cnt, o_first_fail_idx
  );

endinterface

// File: rtl/adder_checker_delay_line.sv
// Fixed-depth shift register carrying a payload with a per-stage valid bit.
module chk_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Valid bits shift one stage per clock; reset empties the line.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= i_valid;
      for (int s = 1; s < DEPTH; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  // Payload shifts alongside its valid bit.
  // NOTE: payload has no reset; the valid bit alone qualifies it.
  always_ff @(posedge i_clk) begin
    data_q[0] <= i_data;
    for (int s = 1; s < DEPTH; s++) begin
      data_q[s] <= data_q[s-1];
    end
  end

  assign o_valid = vld_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];

endmodule

// File: rtl/adder_checker.sv
// Response checker: golden sum, latency-matched compare, pass/fail counters.
module adder_checker
  import adder_chk_pkg::*;
#(
  parameter int A         = 8,
  parameter int B         = 8,
  parameter int ADDER_0   = sum_width(A, B),
  parameter int LATENCY   = 1,
  parameter int N_VECTORS = 256,
  parameter int CNT_W     = 16
) (
  input logic            i_clk,
  input logic            i_reset,
  adder_checker_if.slave bus
);

  localparam int               VEC_W      = $clog2(N_VECTORS + 1);
  localparam int               PW         = ADDER_0 + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] IDX_INIT   = CNT_W'(IDX_NONE);
  localparam logic [3:0]       DRAIN_LAST = 4'(LATENCY - 1);

  chk_state_e         state_q, state_d;
  logic [VEC_W-1:0]   vec_cnt_q;
  logic [3:0]         drain_cnt_q;
  logic [A-1:0]       op_a;
  logic [B-1:0]       op_b;
  logic [ADDER_0-1:0] golden;
  logic [CNT_W-1:0]   push_idx;
  logic               start_run;
  logic               push_valid;
  logic               head_valid;
  logic [PW-1:0]      head_data;
  logic [ADDER_0-1:0] head_sum;
  logic [CNT_W-1:0]   head_idx;
  logic [CNT_W-1:0]   pass_q, fail_q, ffi_q;
  logic               err_q, mism_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign op_a = bus.op_a;
  assign op_b = bus.op_b;

  // Both operands are zero-extended first so the carry-out survives.
  assign golden = ADDER_0'(op_a) + ADDER_0'(op_b);

  // A run can only be (re)started from a quiescent state.
  assign start_run  = bus.i_start && (state_q == IDLE || state_q == DONE);
  assign push_valid = (state_q == RUN) && bus.i_valid &&
                      (vec_cnt_q < VEC_W'(N_VECTORS));

  // Vector index tagged onto each entry, clamped when it exceeds the counter width.
  always_comb begin
    push_idx = CNT_MAX;
    if (32'(vec_cnt_q) < 32'(CNT_MAX)) push_idx = CNT_W'(vec_cnt_q);
  end

  chk_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (PW)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (push_valid),
    .i_data  ({golden, push_idx}),
    .o_valid (head_valid),
    .o_data  (head_data)
  );

  assign head_sum = head_data[PW-1:CNT_W];
  assign head_idx = head_data[CNT_W-1:0];

  // State register.
  // NOTE: non-blocking so every flop samples pre-edge values whatever the block order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode; RUN leaves one cycle after the final vector is taken.
  // NOTE: state_d is defaulted first so no branch can leave it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_start) state_d = RUN;
      RUN:     if (vec_cnt_q == VEC_W'(N_VECTORS)) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
      DONE:    if (bus.i_start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // DRAIN lasts exactly LATENCY cycles so the last entries reach the pipe head.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                drain_cnt_q <= '0;
    else if (state_q == DRAIN)  drain_cnt_q <= drain_cnt_q + 4'd1;
    else                        drain_cnt_q <= '0;
  end

  // Vector index, comparator and saturating result counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vec_cnt_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      ffi_q     <= IDX_INIT;
      err_q     <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      mism_q <= 1'b0;
      if (start_run) begin
        vec_cnt_q <= '0;
        pass_q    <= '0;
        fail_q    <= '0;
        ffi_q     <= IDX_INIT;
        err_q     <= 1'b0;
      end else begin
        if (push_valid) vec_cnt_q <= vec_cnt_q + VEC_W'(1);
        if (head_valid) begin
          if (head_sum == bus.i_sum) begin
            pass_q <= sat_inc(pass_q);
          end else begin
            fail_q <= sat_inc(fail_q);
            mism_q <= 1'b1;
            err_q  <= 1'b1;
            if (!err_q) ffi_q <= head_idx;
          end
        end
      end
    end
  end

  assign bus.o_busy           = (state_q == RUN) || (state_q == DRAIN);
  assign bus.o_done           = (state_q == DONE);
  assign bus.o_mismatch       = mism_q;
  assign bus.o_error          = err_q;
  assign bus.o_pass_cnt       = pass_q;
  assign bus.o_fail_cnt       = fail_q;
  assign bus.o_first_fail_idx = ffi_q;

endmodule

// File: tb/tb_adder_checker.sv
// Self-checking bench: four checker instances share one stimulus stream; each
// sees its own emulated DUT and is scored against a vector-list reference model.
module tb_adder_checker;

  localparam int NU = 4;
  localparam int NV  [NU] = '{4, 4, 6, 8};
  localparam int LAT [NU] = '{1, 3, 1, 8};
  localparam int CW  [NU] = '{16, 16, 2, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  int         mode [NU];
  logic [8:0] fpipe [NU][8];

  logic [15:0] pass_o [NU];
  logic [15:0] fail_o [NU];
  logic [15:0] ffi_o  [NU];
  logic        busy_o [NU];
  logic        done_o [NU];
  logic        mism_o [NU];
  logic        err_o  [NU];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int done_edge [NU];
  int last_edge [NU];
  int mism_cnt  [NU];

  logic [7:0] va [16];
  logic [7:0] vb [16];
  int         bub [16];
  int         n_drive = 8;
  bit         ign_start = 1'b0;

  adder_checker_if #(.CNT_W(16)) if_l1 ();
  adder_checker_if #(.CNT_W(16)) if_l3 ();
  adder_checker_if #(.CNT_W(2))  if_sat ();
  adder_checker_if #(.CNT_W(16)) if_l8 ();

  adder_checker #(.LATENCY(1), .N_VECTORS(4), .CNT_W(16)) u_l1 (.i_clk(clk), .i_reset(rst), .bus(if_l1));
  adder_checker #(.LATENCY(3), .N_VECTORS(4), .CNT_W(16)) u_l3 (.i_clk(clk), .i_reset(rst), .bus(if_l3));
  adder_checker #(.LATENCY(1), .N_VECTORS(6), .CNT_W(2))  u_sat (.i_clk(clk), .i_reset(rst), .bus(if_sat));
  adder_checker #(.LATENCY(8), .N_VECTORS(8), .CNT_W(16)) u_l8 (.i_clk(clk), .i_reset(rst), .bus(if_l8));

  // Emulated adder under test: mode 0 correct, 1 drops the carry, 2 flips bit 0.
  function automatic logic [8:0] dut_sum(input int m, input logic [7:0] x, input logic [7:0] y);
    int s;
    s = int'(x) + int'(y);
    if (m == 1) s = s % 256;
    if (m == 2) s = s ^ 1;
    return 9'(s);
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      fpipe[u][0] <= dut_sum(mode[u], a, b);
      for (int s = 1; s < 8; s++) fpipe[u][s] <= fpipe[u][s-1];
    end
  end

  assign if_l1.i_start = start;  assign if_l1.i_valid = valid;
  assign if_l1.op_a = a;         assign if_l1.op_b = b;   assign if_l1.i_sum = fpipe[0][0];
  assign if_l3.i_start = start;  assign if_l3.i_valid = valid;
  assign if_l3.op_a = a;         assign if_l3.op_b = b;   assign if_l3.i_sum = fpipe[1][2];
  assign if_sat.i_start = start; assign if_sat.i_valid = valid;
  assign if_sat.op_a = a;        assign if_sat.op_b = b;  assign if_sat.i_sum = fpipe[2][0];
  assign if_l8.i_start = start;  assign if_l8.i_valid = valid;
  assign if_l8.op_a = a;         assign if_l8.op_b = b;   assign if_l8.i_sum = fpipe[3][7];

  assign pass_o[0] = if_l1.o_pass_cnt;  assign fail_o[0] = if_l1.o_fail_cnt;  assign ffi_o[0] = if_l1.o_first_fail_idx;
  assign pass_o[1] = if_l3.o_pass_cnt;  assign fail_o[1] = if_l3.o_fail_cnt;  assign ffi_o[1] = if_l3.o_first_fail_idx;
  assign pass_o[2] = 16'(if_sat.o_pass_cnt);
  assign fail_o[2] = 16'(if_sat.o_fail_cnt);
  assign ffi_o[2]  = 16'(if_sat.o_first_fail_idx);
  assign pass_o[3] = if_l8.o_pass_cnt;  assign fail_o[3] = if_l8.o_fail_cnt;  assign ffi_o[3] = if_l8.o_first_fail_idx;
  assign busy_o[0] = if_l1.o_busy;  assign done_o[0] = if_l1.o_done;  assign mism_o[0] = if_l1.o_mismatch;  assign err_o[0] = if_l1.o_error;
  assign busy_o[1] = if_l3.o_busy;  assign done_o[1] = if_l3.o_done;  assign mism_o[1] = if_l3.o_mismatch;  assign err_o[1] = if_l3.o_error;
  assign busy_o[2] = if_sat.o_busy; assign done_o[2] = if_sat.o_done; assign mism_o[2] = if_sat.o_mismatch; assign err_o[2] = if_sat.o_error;
  assign busy_o[3] = if_l8.o_busy;  assign done_o[3] = if_l8.o_done;  assign mism_o[3] = if_l8.o_mismatch;  assign err_o[3] = if_l8.o_error;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int u = 0; u < NU; u++) begin
      if (done_o[u] && done_edge[u] < 0) done_edge[u] = cyc;
      if (mism_o[u]) mism_cnt[u]++;
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] xa, input logic [7:0] xb);
    start = s; valid = v; a = xa; b = xb;
    tick();
  endtask

  function automatic bit all_done();
    for (int u = 0; u < NU; u++) if (!done_o[u]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: walk the first N vectors of the run and score them by the rules.
  task automatic model(input int u, output int e_pass, output int e_fail,
                       output int e_raw, output int e_ffi);
    int mx;
    mx = (1 << CW[u]) - 1;
    e_pass = 0; e_fail = 0; e_raw = 0; e_ffi = mx;
    for (int i = 0; i < NV[u]; i++) begin
      if (int'(dut_sum(mode[u], va[i], vb[i])) == int'(va[i]) + int'(vb[i])) begin
        if (e_pass < mx) e_pass++;
      end else begin
        e_raw++;
        if (e_fail < mx) e_fail++;
        if (e_raw == 1) e_ffi = (i < mx) ? i : mx;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("%s/u%0d/busy", tag, u), 64'(busy_o[u]), 0);
      check($sformatf("%s/u%0d/done", tag, u), 64'(done_o[u]), 0);
      check($sformatf("%s/u%0d/mismatch", tag, u), 64'(mism_o[u]), 0);
      check($sformatf("%s/u%0d/error", tag, u), 64'(err_o[u]), 0);
      check($sformatf("%s/u%0d/pass", tag, u), 64'(pass_o[u]), 0);
      check($sformatf("%s/u%0d/fail", tag, u), 64'(fail_o[u]), 0);
      check($sformatf("%s/u%0d/ffi", tag, u), 64'(ffi_o[u]), 64'((1 << CW[u]) - 1));
    end
  endtask

  task automatic run_and_check(input string tag);
    int e_pass, e_fail, e_raw, e_ffi;
    for (int u = 0; u < NU; u++) begin
      done_edge[u] = -1; last_edge[u] = -1; mism_cnt[u] = 0;
    end
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("%s/u%0d/start_busy", tag, u), 64'(busy_o[u]), 1);
      check($sformatf("%s/u%0d/start_pass", tag, u), 64'(pass_o[u]), 0);
      check($sformatf("%s/u%0d/start_fail", tag, u), 64'(fail_o[u]), 0);
      check($sformatf("%s/u%0d/start_err", tag, u), 64'(err_o[u]), 0);
      check($sformatf("%s/u%0d/start_ffi", tag, u), 64'(ffi_o[u]), 64'((1 << CW[u]) - 1));
    end
    for (int i = 0; i < n_drive; i++) begin
      for (int k = 0; k < bub[i]; k++) drive(1'b0, 1'b0, 8'($urandom), 8'($urandom));
      drive(ign_start && (i == 1 || i == 5), 1'b1, va[i], vb[i]);
      for (int u = 0; u < NU; u++) if (i == NV[u] - 1) last_edge[u] = cyc;
    end
    for (int t = 0; t < 40 && !all_done(); t++) drive(1'b0, 1'b0, 8'd0, 8'd0);
    for (int u = 0; u < NU; u++) begin
      model(u, e_pass, e_fail, e_raw, e_ffi);
      check($sformatf("%s/u%0d/done", tag, u), 64'(done_o[u]), 1);
      check($sformatf("%s/u%0d/busy", tag, u), 64'(busy_o[u]), 0);
      check($sformatf("%s/u%0d/done_latency", tag, u), 64'(done_edge[u] - last_edge[u]), 64'(LAT[u] + 1));
      check($sformatf("%s/u%0d/pass", tag, u), 64'(pass_o[u]), 64'(e_pass));
      check($sformatf("%s/u%0d/fail", tag, u), 64'(fail_o[u]), 64'(e_fail));
      check($sformatf("%s/u%0d/error", tag, u), 64'(err_o[u]), 64'(e_raw > 0));
      check($sformatf("%s/u%0d/ffi", tag, u), 64'(ffi_o[u]), 64'(e_ffi));
      check($sformatf("%s/u%0d/mismatch_pulses", tag, u), 64'(mism_cnt[u]), 64'(e_raw));
    end
  endtask

  task automatic fill_vectors(input bit directed, input bit bubbles);
    for (int i = 0; i < 16; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
      bub[i] = (bubbles && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    end
    if (directed) begin
      va[0] = 8'd1;   vb[0] = 8'd2;
      va[1] = 8'd255; vb[1] = 8'd255;
      va[2] = 8'd128; vb[2] = 8'd128;
      va[3] = 8'd0;   vb[3] = 8'd0;
    end
  endtask

  initial begin
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    fill_vectors(1'b1, 1'b0);
    mode = '{0, 0, 2, 0};
    run_and_check("correct");

    fill_vectors(1'b1, 1'b0);
    mode = '{1, 1, 1, 1};
    run_and_check("carry_drop");

    fill_vectors(1'b1, 1'b0);
    bub[1] = 1; bub[4] = 1;
    mode = '{0, 0, 0, 0};
    run_and_check("bubbles");

    fill_vectors(1'b0, 1'b0);
    mode = '{0, 2, 0, 1};
    ign_start = 1'b1;
    run_and_check("ignore_start");
    ign_start = 1'b0;

    mode = '{2, 2, 2, 2};
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    drive(1'b0, 1'b1, 8'd10, 8'd20);
    drive(1'b0, 1'b1, 8'd30, 8'd40);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    check("midrun/pre_reset_error", 64'(err_o[0]), 1);
    rst = 1'b1;
    #2;
    check_reset("midrun_reset");
    tick();
    rst = 1'b0;
    tick();
    check_reset("after_release");
    fill_vectors(1'b1, 1'b0);
    mode = '{0, 0, 0, 0};
    run_and_check("clean_after_reset");

    for (int r = 0; r < 8; r++) begin
      fill_vectors(1'b0, 1'b1);
      for (int u = 0; u < NU; u++) mode[u] = int'($urandom_range(0, 2));
      run_and_check($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
